gray_sync_decoder: RTL
======================

// Module: gray_sync_decoder
// PURPOSE
//  Receive side of the gray counter: takes the counter's gray_out into the destination clock domain.
//  - Synchronises it through a flop chain, then decodes gray->binary.
//  - Checks every observed step for gray legality (at most one bit flip).
//  - Reports change/wrap events, modulo step size (delta) and a saturating error count.
// PARAMETERS
//  DATA_WIDTH     4  width of gray_in / bin_out / delta
//  SYNC_STAGES    2  synchroniser depth, >=2
//  ERR_CNT_WIDTH  8  width of err_cnt
// PORTS
//  clk        in   1              destination-domain clock
//  rst_n      in   1              asynchronous, active-low reset
//  gray_in    in   DATA_WIDTH     gray count, asynchronous to clk
//  err_clr    in   1              synchronous clear of err_cnt
//  gray_sync  out  DATA_WIDTH     last synchroniser stage
//  bin_out    out  DATA_WIDTH     registered binary decode of gray_sync
//  ready      out  1              0 during INIT, 1 in TRACK
//  change     out  1              1-cycle pulse: gray_sync differs from previous sample
//  step_err   out  1              1-cycle pulse: more than one bit changed
//  wrap       out  1              1-cycle pulse: binary went all-ones -> 0
//  delta      out  DATA_WIDTH     bin_new - bin_prev mod 2^DATA_WIDTH; holds between changes
//  err_cnt    out  ERR_CNT_WIDTH  saturating count of step_err events
// BEHAVIOUR
//  Reset: all flops async-reset to 0. Every output is 0 under reset, including ready and delta.
//  Sync chain
//   - SYNC_STAGES flops sample gray_in every clk; gray_sync is the last stage.
//   - gray_in is never used combinationally.
//  Decode
//   - b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
//   - bin_out is registered, updated every cycle in both states.
//  FSM INIT
//   - Entered on reset. init_cnt counts clk edges from 0.
//   - When init_cnt == SYNC_STAGES: load prev_gray/prev_bin from gray_sync/its decode, then go to TRACK.
//   - change/step_err/wrap stay 0. delta is not updated.
//   - No event is produced on TRACK entry, even if gray_sync != 0.
//  FSM TRACK
//   - Each cycle: diff = gray_sync ^ prev_gray.
//   - popcount(diff)==0: no pulses.
//   - popcount(diff)==1: change=1; delta = bin_new - prev_bin.
//       wrap=1 iff prev_bin == all-ones and bin_new == 0.
//   - popcount(diff)>1: change=1 and step_err=1; delta is computed the same way.
//       wrap is computed by the same rule.
//   - prev_gray/prev_bin are updated every cycle, including on errors: the next step is judged from the new value.
//   - TRACK exits only on reset.
//  Latency
//   - A gray_in value sampled at edge k appears on gray_sync after edge k+SYNC_STAGES-1.
//   - bin_out, change, step_err, wrap and delta follow one edge later (edge k+SYNC_STAGES).
//  err_cnt
//   - Increments on step_err and saturates at all-ones; no wrap.
//   - err_clr=1 sets it to 0 next edge. err_clr has priority over a simultaneous step_err, which is not counted.
//  Reset mid-operation: all state returns to 0 asynchronously. INIT is re-run in full after release.
// TESTING
//  1 gray_in=0, release reset -> ready=1 after SYNC_STAGES+1 edges; change/step_err/wrap never pulse.
//  2 gray_in=0110 held through reset -> after INIT, bin_out=0100, ready=1, no change pulse on TRACK entry.
//  3 gray sequence for binary 0..15..0, one step per 4 clks -> bin_out tracks with SYNC_STAGES+1 latency.
//      Expect 16 change pulses, each with delta=1. wrap pulses once (1000->0000). step_err never pulses.
//  4 Gray jump 0000->0011 in TRACK -> change=1, step_err=1, delta=0010, err_cnt=1.
//      prev updated: a following 0011->0010 is legal.
//  5 Illegal steps 260 times -> err_cnt saturates at 255.
//      err_clr coincident with step_err -> err_cnt=0 next edge.
//  6 Assert rst_n mid-sequence at gray_in=0101 -> all outputs 0 immediately.
//      After release, ready stays 0 for SYNC_STAGES+1 edges, then bin_out=0110 with no pulses.

Source files
------------

// File: rtl/gray_sync_decoder.sv
// Destination-domain receiver for a gray counter: synchroniser chain, gray->binary
// decode, per-step legality check, change/wrap/delta events and a saturating error count.
module gray_sync_decoder #(
  parameter int DATA_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    gray_in,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    gray_sync,
  output logic [DATA_WIDTH-1:0]    bin_out,
  output logic                     ready,
  output logic                     change,
  output logic                     step_err,
  output logic                     wrap,
  output logic [DATA_WIDTH-1:0]    delta,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     dbg_state
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            init_cnt_q;
  logic [DATA_WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]    prev_gray_q;
  logic [DATA_WIDTH-1:0]    prev_bin_q;
  logic [DATA_WIDTH-1:0]    bin_q;
  logic [DATA_WIDTH-1:0]    delta_q;
  logic                     change_q;
  logic                     step_err_q;
  logic                     wrap_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic [DATA_WIDTH-1:0]    bin_d;
  logic [DATA_WIDTH-1:0]    diff_d;
  logic                     moved_d;
  logic                     multi_d;
  logic                     wrap_d;

  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign gray_sync = sync_q[SYNC_STAGES-1];

  // Step classification: any flipped bit is a change, more than one is illegal.
  always_comb begin
    bin_d   = gray2bin(gray_sync);
    diff_d  = gray_sync ^ prev_gray_q;
    moved_d = (diff_d != '0);
    multi_d = moved_d && !$onehot0(diff_d);
    wrap_d  = (prev_bin_q == '1) && (bin_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      change_q    <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bin_q      <= bin_d;
      change_q   <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      case (state_q)
        ST_INIT: begin
          // Wait for the chain to fill, then adopt the current value silently.
          if (init_cnt_q == CW'(SYNC_STAGES)) begin
            prev_gray_q <= gray_sync;
            prev_bin_q  <= bin_d;
            state_q     <= ST_TRACK;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        ST_TRACK: begin
          prev_gray_q <= gray_sync;
          prev_bin_q  <= bin_d;
          if (moved_d) begin
            change_q   <= 1'b1;
            step_err_q <= multi_d;
            wrap_q     <= wrap_d;
            delta_q    <= bin_d - prev_bin_q;
          end
        end
        default: state_q <= ST_INIT;
      endcase
      // Clear wins over an error registered on the same edge.
      if (err_clr) begin
        err_cnt_q <= '0;
      end else if (state_q == ST_TRACK && multi_d && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bin_out   = bin_q;
  assign ready     = (state_q == ST_TRACK);
  assign change    = change_q;
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign delta     = delta_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule
